// File: rtl/serial_mag_comparator_if.sv
// Start/busy/done handshake, operands and result flags for serial_mag_comparator.
// The requester uses the master modport; the comparator uses the slave modport.
interface serial_mag_comparator_if #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
);
  localparam int NSLICE = WIDTH / DIGIT;
  localparam int SU_W   = $clog2(NSLICE) + 1;

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;
  logic [SU_W-1:0]  slices_used;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, a_gt_b, a_lt_b, a_eq_b, slices_used
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, a_gt_b, a_lt_b, a_eq_b, slices_used
  );
endinterface

// File: rtl/serial_mag_comparator.sv
// Multi-cycle magnitude comparator: walks DIGIT-bit slices from the MSB down and
// stops at the first differing slice. Signed compares use an offset-binary remap.
module serial_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_mag_comparator_if.slave bus
);
  localparam int NSLICE = WIDTH / DIGIT;
  localparam int SU_W   = $clog2(NSLICE) + 1;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_mag_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IDX_W-1:0] idx;
  logic [SU_W-1:0]  count;
  logic             busy_r;
  logic             done_r;
  logic             gt_r;
  logic             lt_r;
  logic             eq_r;
  logic [SU_W-1:0]  slices_r;
  logic [DIGIT-1:0] a_slice;
  logic [DIGIT-1:0] b_slice;

  always_comb begin
    a_slice = a_reg[int'(idx)*DIGIT +: DIGIT];
    b_slice = b_reg[int'(idx)*DIGIT +: DIGIT];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      idx      <= '0;
      count    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      gt_r     <= 1'b0;
      lt_r     <= 1'b0;
      eq_r     <= 1'b0;
      slices_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order.
            a_reg  <= bus.signed_mode ? (bus.a ^ MSB_MASK) : bus.a;
            b_reg  <= bus.signed_mode ? (bus.b ^ MSB_MASK) : bus.b;
            idx    <= IDX_W'(NSLICE - 1);
            count  <= '0;
            busy_r <= 1'b1;
            state  <= COMPARE;
          end
        end

        COMPARE: begin
          if (a_slice != b_slice) begin
            gt_r     <= (a_slice > b_slice);
            lt_r     <= (a_slice < b_slice);
            eq_r     <= 1'b0;
            slices_r <= count + SU_W'(1);
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state    <= DONE;
          end else if (idx == '0) begin
            gt_r     <= 1'b0;
            lt_r     <= 1'b0;
            eq_r     <= 1'b1;
            slices_r <= SU_W'(NSLICE);
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state    <= DONE;
          end else begin
            idx   <= idx - IDX_W'(1);
            count <= count + SU_W'(1);
          end
        end

        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.a_gt_b      = gt_r;
  assign bus.a_lt_b      = lt_r;
  assign bus.a_eq_b      = eq_r;
  assign bus.slices_used = slices_r;
endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator: a 16/4 instance and an 8/8 instance,
// directed table, randomized compares against an arithmetic reference, and corner sequences.
module tb_serial_mag_comparator;
  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;
  localparam int TIMEOUT = 40;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_mag_comparator_if #(.WIDTH(16), .DIGIT(4)) bus16 ();
  serial_mag_comparator_if #(.WIDTH(8),  .DIGIT(8)) bus8 ();

  serial_mag_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  serial_mag_comparator #(.WIDTH(8),  .DIGIT(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct {
    bit          sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [2:0]  flags;
    int          n;
  } vec_t;

  vec_t vecs[10];
  int check_count = 0;
  int pass_count  = 0;

  logic [2:0] res_flags;
  int res_su, res_lat, res_busy_bad, res_hold_bad;
  logic res_done_after, res_busy_after;

  function automatic logic [2:0] cur_flags(input bit sel);
    return sel ? {bus8.a_gt_b, bus8.a_lt_b, bus8.a_eq_b}
               : {bus16.a_gt_b, bus16.a_lt_b, bus16.a_eq_b};
  endfunction

  function automatic logic cur_done(input bit sel);
    return sel ? bus8.done : bus16.done;
  endfunction

  function automatic logic cur_busy(input bit sel);
    return sel ? bus8.busy : bus16.busy;
  endfunction

  function automatic int cur_su(input bit sel);
    return sel ? int'(bus8.slices_used) : int'(bus16.slices_used);
  endfunction

  // Reference: plain integer compare plus position of the highest differing slice.
  function automatic void ref_model(input logic [15:0] a, input logic [15:0] b, input logic sm,
                                    input int width, input int digit,
                                    output logic [2:0] fl, output int n);
    int ns = width / digit;
    int mask = (1 << width) - 1;
    int ai = int'(a) & mask;
    int bi = int'(b) & mask;
    int x = ai ^ bi;
    if (sm) begin
      if (ai >= (1 << (width - 1))) ai = ai - (1 << width);
      if (bi >= (1 << (width - 1))) bi = bi - (1 << width);
    end
    fl = (ai > bi) ? GT : (ai < bi) ? LT : EQ;
    n = ns;
    for (int s = ns - 1; s >= 0; s--) begin
      if (((x >> (s * digit)) & ((1 << digit) - 1)) != 0) begin
        n = ns - s;
        break;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic drive(input bit sel, input logic [15:0] a, input logic [15:0] b,
                       input logic sm, input logic st);
    if (sel) begin
      bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.signed_mode = sm; bus8.start = st;
    end else begin
      bus16.a = a; bus16.b = b; bus16.signed_mode = sm; bus16.start = st;
    end
  endtask

  task automatic set_start(input bit sel, input logic st);
    if (sel) bus8.start = st;
    else bus16.start = st;
  endtask

  // One full compare: start pulse, wait for done, then one cycle after done.
  task automatic applyStimulus(input bit sel, input logic [15:0] a, input logic [15:0] b, input logic sm);
    logic [2:0] prev;
    @(negedge clk);
    drive(sel, a, b, sm, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    res_lat = 1;
    res_busy_bad = 0;
    res_hold_bad = 0;
    prev = cur_flags(sel);
    while (!cur_done(sel) && res_lat < TIMEOUT) begin
      if (!cur_busy(sel)) res_busy_bad++;
      if (cur_flags(sel) !== prev) res_hold_bad++;
      @(negedge clk);
      res_lat++;
    end
    if (!cur_done(sel)) begin
      check_count++;
      $display("[TB] FAIL timeout: done not seen within %0d cycles", TIMEOUT);
    end
    res_flags = cur_flags(sel);
    res_su = cur_su(sel);
    @(negedge clk);
    res_done_after = cur_done(sel);
    res_busy_after = cur_busy(sel);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] exp_fl;
    int exp_n;
    int pulses, first_k, second_k, busy_after;
    logic [2:0] iso_flags;
    int iso_su;

    vecs[0] = '{1'b0, 16'hA000, 16'h1FFF, 1'b0, GT, 1};
    vecs[1] = '{1'b0, 16'h1234, 16'h1235, 1'b0, LT, 4};
    vecs[2] = '{1'b0, 16'hBEEF, 16'hBEEF, 1'b0, EQ, 4};
    vecs[3] = '{1'b0, 16'hFFFF, 16'h0001, 1'b1, LT, 1};
    vecs[4] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, GT, 1};
    vecs[5] = '{1'b0, 16'h8000, 16'h7FFF, 1'b1, LT, 1};
    vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b1, EQ, 4};
    vecs[7] = '{1'b0, 16'h1200, 16'h1300, 1'b0, LT, 2};
    vecs[8] = '{1'b1, 16'h007F, 16'h0080, 1'b0, LT, 1};
    vecs[9] = '{1'b1, 16'h007F, 16'h0080, 1'b1, GT, 1};

    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset busy", {31'b0, bus16.busy}, 32'd0);
    checkOutput("reset done", {31'b0, bus16.done}, 32'd0);
    checkOutput("reset flags16", {29'b0, cur_flags(1'b0)}, 32'd0);
    checkOutput("reset slices_used", cur_su(1'b0), 32'd0);
    checkOutput("reset flags8", {29'b0, cur_flags(1'b1)}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle flags before first compare", {29'b0, cur_flags(1'b0)}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sm);
      checkOutput($sformatf("vec%0d flags", i), {29'b0, res_flags}, {29'b0, vecs[i].flags});
      checkOutput($sformatf("vec%0d slices_used", i), res_su, vecs[i].n);
      checkOutput($sformatf("vec%0d latency", i), res_lat, vecs[i].n + 1);
      checkOutput($sformatf("vec%0d busy while comparing", i), res_busy_bad, 32'd0);
      checkOutput($sformatf("vec%0d flags held while busy", i), res_hold_bad, 32'd0);
      checkOutput($sformatf("vec%0d single done pulse", i), {31'b0, res_done_after}, 32'd0);
    end

    for (int i = 0; i < 60; i++) begin
      logic [15:0] ra, rb;
      logic rsm;
      bit rsel;
      int mode;
      rsel = (i % 4 == 3);
      ra = 16'($urandom);
      mode = $urandom_range(0, 3);
      if (mode == 0) rb = ra;
      else if (mode == 1) rb = ra ^ (16'h1 << $urandom_range(0, 15));
      else rb = 16'($urandom);
      rsm = 1'($urandom_range(0, 1));
      if (rsel) begin
        ra[15:8] = 8'h0;
        rb[15:8] = 8'h0;
        ref_model(ra, rb, rsm, 8, 8, exp_fl, exp_n);
      end else begin
        ref_model(ra, rb, rsm, 16, 4, exp_fl, exp_n);
      end
      applyStimulus(rsel, ra, rb, rsm);
      checkOutput($sformatf("rand%0d flags a=%h b=%h sm=%0d", i, ra, rb, rsm), {29'b0, res_flags}, {29'b0, exp_fl});
      checkOutput($sformatf("rand%0d slices_used", i), res_su, exp_n);
      checkOutput($sformatf("rand%0d latency", i), res_lat, exp_n + 1);
    end

    // Operand isolation and an ignored start pulse during COMPARE.
    @(negedge clk);
    drive(1'b0, 16'h1234, 16'h1235, 1'b0, 1'b1);
    pulses = 0; first_k = 0; busy_after = 0; iso_flags = 3'b0; iso_su = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus16.done) begin
        pulses++;
        if (first_k == 0) begin
          first_k = k; iso_flags = cur_flags(1'b0); iso_su = cur_su(1'b0);
        end
      end else if (pulses > 0 && bus16.busy) busy_after++;
      if (k == 1) drive(1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
      if (k == 2) set_start(1'b0, 1'b1);
      if (k == 3) set_start(1'b0, 1'b0);
    end
    checkOutput("isolation flags", {29'b0, iso_flags}, {29'b0, LT});
    checkOutput("isolation slices_used", iso_su, 32'd4);
    checkOutput("isolation latency", first_k, 32'd5);
    checkOutput("isolation done pulses", pulses, 32'd1);
    checkOutput("isolation extra start ignored", busy_after, 32'd0);

    // Reset asserted in the second COMPARE cycle.
    @(negedge clk);
    drive(1'b0, 16'h1234, 16'h1235, 1'b0, 1'b1);
    @(negedge clk);
    set_start(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", {31'b0, bus16.busy}, 32'd0);
    checkOutput("abort done", {31'b0, bus16.done}, 32'd0);
    checkOutput("abort flags", {29'b0, cur_flags(1'b0)}, 32'd0);
    checkOutput("abort slices_used", cur_su(1'b0), 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus16.done || bus16.busy) pulses++;
    end
    checkOutput("abort no done afterwards", pulses, 32'd0);
    applyStimulus(1'b0, 16'hA000, 16'h1FFF, 1'b0);
    checkOutput("after abort flags", {29'b0, res_flags}, {29'b0, GT});
    checkOutput("after abort latency", res_lat, 32'd2);

    // start held high: a new compare on every return to IDLE, spaced n+2 cycles.
    @(negedge clk);
    drive(1'b0, 16'h1200, 16'h1300, 1'b0, 1'b1);
    first_k = 0; second_k = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus16.done) begin
        if (first_k == 0) first_k = k;
        else if (second_k == 0) second_k = k;
      end
    end
    set_start(1'b0, 1'b0);
    checkOutput("held start first done", first_k, 32'd3);
    checkOutput("held start spacing", second_k - first_k, 32'd4);
    checkOutput("held start flags", {29'b0, cur_flags(1'b0)}, {29'b0, LT});
    repeat (10) @(negedge clk);
    checkOutput("held start drained", {31'b0, bus16.busy}, 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
